// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared bus widths, op codes and arbiter encodings
package mem_arbiter_pkg;

    localparam int DATA_BUS = 16;
    localparam int ADDR_BUS = 18;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_CAPT  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port IF/MEM arbiter sequencing the SRAM driver protocol
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_BUS,
    parameter int ADDR_W = ADDR_BUS
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              busy,
    output logic              drv_en,
    output logic              drv_op,
    output logic [ADDR_W-1:0] drv_addr,
    output logic [DATA_W-1:0] drv_wdata,
    input  logic [DATA_W-1:0] drv_rdata
);

    arb_state_t state, next_state;
    grant_t     grant;
    logic       accept_mem;
    logic       accept_if;

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // MEM wins any tie; IF is only looked at when mem_req is low.
    always_comb begin
        next_state = state;
        accept_mem = 1'b0;
        accept_if  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (mem_req) begin
                    accept_mem = 1'b1;
                    next_state = ARB_ISSUE;
                end else if (if_req) begin
                    accept_if  = 1'b1;
                    next_state = ARB_ISSUE;
                end
            end
            ARB_ISSUE: next_state = ARB_WAIT;
            ARB_WAIT:  next_state = ARB_CAPT;
            ARB_CAPT:  next_state = ARB_IDLE;
            default:   next_state = ARB_IDLE;
        endcase
    end

    assign busy = (state != ARB_IDLE);

    // Driver-side fields load only on accept so the bus stays stable through IDLE.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            grant     <= GNT_NONE;
            drv_en    <= 1'b0;
            drv_op    <= OP_RD;
            drv_addr  <= '0;
            drv_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            drv_en   <= (next_state == ARB_ISSUE);
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            if (accept_mem) begin
                grant     <= GNT_MEM;
                drv_op    <= mem_we;
                drv_addr  <= mem_addr;
                drv_wdata <= mem_wdata;
            end else if (accept_if) begin
                grant    <= GNT_IF;
                drv_op   <= OP_RD;
                drv_addr <= if_addr;
            end
            if (state == ARB_CAPT) begin
                grant <= GNT_NONE;
                case (grant)
                    GNT_IF: begin
                        if_rdata <= drv_rdata;
                        if_done  <= 1'b1;
                    end
                    GNT_MEM: begin
                        if (drv_op == OP_RD) begin
                            mem_rdata <= drv_rdata;
                        end
                        mem_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural SRAM
module tb_mem_arbiter;

    logic        clk_50MHz;
    logic        rst;
    logic        if_req;
    logic [17:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        busy;
    logic        drv_en;
    logic        drv_op;
    logic [17:0] drv_addr;
    logic [15:0] drv_wdata;
    logic [15:0] drv_rdata;

    mem_arbiter #(.DATA_W(16), .ADDR_W(18)) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy),
        .drv_en    (drv_en),
        .drv_op    (drv_op),
        .drv_addr  (drv_addr),
        .drv_wdata (drv_wdata),
        .drv_rdata (drv_rdata)
    );

    initial begin
        clk_50MHz = 1'b0;
        forever #10 clk_50MHz = ~clk_50MHz;
    end

    // Driver + SRAM stand-in: command taken on the drv_en edge, read data ready before CAPT ends.
    bit   [15:0] sram [0:262143];
    logic [15:0] rd_lat;
    always @(posedge clk_50MHz) begin
        if (drv_en) begin
            if (drv_op) sram[drv_addr] <= drv_wdata;
            else        rd_lat <= sram[drv_addr];
        end
    end
    assign drv_rdata = rd_lat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk_50MHz) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_mem;
        logic [15:0] data;
    } exp_t;
    exp_t        sb[$];
    logic [15:0] exp_mem_last = 16'h0;

    // Monitor: pops one expectation per done pulse; also protocol invariants.
    logic        prev_en = 1'b0;
    logic        held_op;
    logic [17:0] held_addr;
    logic [15:0] held_wdata;
    always @(negedge clk_50MHz) begin
        if (!rst) begin
            if (if_done && mem_done) chk("both_done", 32'd1, 32'd0);
            if (prev_en && drv_en) chk("drv_en_consecutive", 32'd1, 32'd0);
            if (if_done || mem_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_port", {31'd0, mem_done}, {31'd0, e.is_mem});
                    if (e.is_mem) chk("mem_rdata", {16'd0, mem_rdata}, {16'd0, e.data});
                    else          chk("if_rdata", {16'd0, if_rdata}, {16'd0, e.data});
                end
            end
            if (drv_en) begin
                held_op    = drv_op;
                held_addr  = drv_addr;
                held_wdata = drv_wdata;
            end else if (busy) begin
                chk("drv_hold", {drv_op, drv_addr, drv_wdata[12:0]},
                    {held_op, held_addr, held_wdata[12:0]});
            end
        end
        prev_en = drv_en;
    end

    task automatic wait_done(input logic is_mem, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 20) begin
            @(negedge clk_50MHz);
            if ((is_mem && mem_done) || (!is_mem && if_done)) begin
                at = cyc;
                break;
            end
            n++;
        end
        if (at < 0) chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_if(input logic [17:0] a, input logic [15:0] d);
        int at;
        @(negedge clk_50MHz);
        if_req  = 1'b1;
        if_addr = a;
        sb.push_back('{is_mem: 1'b0, data: d});
        wait_done(1'b0, at);
        if_req = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [17:0] a, input logic [15:0] wd,
                          input logic [15:0] rd);
        int at;
        @(negedge clk_50MHz);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = wd;
        if (!we) exp_mem_last = rd;
        sb.push_back('{is_mem: 1'b1, data: exp_mem_last});
        wait_done(1'b1, at);
        mem_req = 1'b0;
    endtask

    initial begin
        int t0;
        int at;
        int prev_at;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        sram[18'h00010] = 16'h1234;
        sram[18'h00000] = 16'h0F0F;
        sram[18'h00001] = 16'hAAAA;
        sram[18'h00002] = 16'h5555;
        sram[18'h00020] = 16'h1111;
        sram[18'h00021] = 16'h2222;
        sram[18'h00022] = 16'h3333;
        repeat (3) @(negedge clk_50MHz);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_drv", {drv_en, drv_op, drv_addr, drv_wdata[11:0]}, 32'd0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 32'd0);
        chk("rst_done", {30'd0, if_done, mem_done}, 32'd0);
        rst = 1'b0;

        // 1: IF fetch with latency checks
        @(negedge clk_50MHz);
        if_req = 1'b1; if_addr = 18'h00010; t0 = cyc;
        sb.push_back('{is_mem: 1'b0, data: 16'h1234});
        @(negedge clk_50MHz);
        chk("issue_latency", {31'd0, drv_en}, 32'd1);
        chk("issue_addr", {14'd0, drv_addr}, 32'h00010);
        wait_done(1'b0, at);
        if_req = 1'b0;
        chk("if_done_latency", at - t0, 32'd4);

        // 2: top-address write then read back
        do_mem(1'b1, 18'h3FFFF, 16'hBEEF, 16'h0);
        chk("sram_top", {16'd0, sram[18'h3FFFF]}, 32'hBEEF);
        chk("sram_nowrap", {16'd0, sram[18'h00000]}, 32'h0F0F);
        do_mem(1'b0, 18'h3FFFF, 16'h0, 16'hBEEF);

        // 3: simultaneous requests, MEM first
        @(negedge clk_50MHz);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00002;
        if_req  = 1'b1; if_addr = 18'h00001; t0 = cyc;
        exp_mem_last = 16'h5555;
        sb.push_back('{is_mem: 1'b1, data: 16'h5555});
        sb.push_back('{is_mem: 1'b0, data: 16'hAAAA});
        wait_done(1'b1, at);
        mem_req = 1'b0;
        chk("tie_mem_latency", at - t0, 32'd4);
        wait_done(1'b0, at);
        if_req = 1'b0;
        chk("tie_if_latency", at - t0, 32'd8);

        // 4: back-to-back fetches with req held high
        @(negedge clk_50MHz);
        if_req = 1'b1; if_addr = 18'h00020;
        sb.push_back('{is_mem: 1'b0, data: 16'h1111});
        prev_at = 0;
        for (int i = 0; i < 3; i++) begin
            wait_done(1'b0, at);
            if (i > 0) chk("b2b_spacing", at - prev_at, 32'd4);
            prev_at = at;
            if (i == 0) begin
                if_addr = 18'h00021;
                sb.push_back('{is_mem: 1'b0, data: 16'h2222});
            end else if (i == 1) begin
                if_addr = 18'h00022;
                sb.push_back('{is_mem: 1'b0, data: 16'h3333});
            end else begin
                if_req = 1'b0;
            end
        end

        // 5: reset during WAIT of a read
        @(negedge clk_50MHz);
        if_req = 1'b1; if_addr = 18'h00010;
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        chk("in_wait", {30'd0, busy, drv_en}, 32'd2);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk_50MHz);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_en", {31'd0, drv_en}, 32'd0);
        chk("mid_rst_rdata", {if_rdata, mem_rdata}, 32'd0);
        chk("mid_rst_done", {30'd0, if_done, mem_done}, 32'd0);
        rst = 1'b0;
        exp_mem_last = 16'h0;
        repeat (4) begin
            @(negedge clk_50MHz);
            chk("post_rst_quiet", {30'd0, if_done, mem_done}, 32'd0);
        end
        do_if(18'h00002, 16'h5555);

        // 6: inputs scrambled during the access
        @(negedge clk_50MHz);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00100; mem_wdata = 16'hCAFE;
        sb.push_back('{is_mem: 1'b1, data: exp_mem_last});
        repeat (3) begin
            @(negedge clk_50MHz);
            mem_addr  = 18'($urandom_range(18'h3FFFF, 18'h00200));
            mem_wdata = 16'($urandom);
            mem_we    = 1'($urandom);
        end
        wait_done(1'b1, at);
        mem_req = 1'b0;
        chk("scramble_sram", {16'd0, sram[18'h00100]}, 32'hCAFE);
        do_mem(1'b0, 18'h00100, 16'h0, 16'hCAFE);

        repeat (3) @(negedge clk_50MHz);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
